// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order requests to instruction memory,
// a DEPTH-entry {pc, instruction} buffer to decode, redirect flush. Option macro: FETCH_PERF_EN.

module fetch_unit_chk (
    input logic clk,
    input logic rst_n,
    input logic resp_valid,
    input logic buf_full
);
    // The credit rule guarantees room for every response that arrives.
    a_no_resp_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(resp_valid && buf_full))
        else $error("fetch_unit: response arrived with the instruction buffer full");
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam int            SW       = CW + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_fire;
    logic          w_credit;
    logic [SW-1:0] w_used;
    logic [CW-1:0] w_out_nxt;
    logic [31:0]   w_redir_pc;
    logic          w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused   = ^redirect_pc[1:0];

    assign id_valid       = (r_count != {CW{1'b0}});
    assign id_instruction = r_ins_mem[r_head];
    assign id_pc          = r_pc_mem[r_head];
    assign w_pop          = id_valid && id_ready;

    // A slot freed by this cycle's pop counts as a credit, so a latency-1 memory streams at full rate.
    assign w_used   = SW'(r_out_cnt) + SW'(r_count) - SW'(w_pop);
    assign w_credit = (w_used < SW'(DEPTH));

    assign imem_req_valid = w_credit && !redirect_valid && rst_n;
    assign imem_req_addr  = {r_fetch_pc[31:2], 2'b00};
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_push         = imem_resp_valid && (r_drop_cnt == {CW{1'b0}}) && !redirect_valid;

    // Next outstanding-request count from issue and return.
    always_comb begin
        w_out_nxt = r_out_cnt;
        if (w_fire && !imem_resp_valid) begin
            w_out_nxt = r_out_cnt + ONE_C;
        end else if (!w_fire && imem_resp_valid) begin
            w_out_nxt = r_out_cnt - ONE_C;
        end else begin
            w_out_nxt = r_out_cnt;
        end
    end

    // Fetch address, response pc tracker, and request/drop bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out_cnt  <= {CW{1'b0}};
            r_drop_cnt <= {CW{1'b0}};
        end else begin
            r_out_cnt <= w_out_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_drop_cnt <= imem_resp_valid ? (r_out_cnt - ONE_C) : r_out_cnt;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (imem_resp_valid && (r_drop_cnt != {CW{1'b0}})) begin
                    r_drop_cnt <= r_drop_cnt - ONE_C;
                end
            end
        end
    end

    // Buffer pointers and occupancy; redirect flushes regardless of a coincident pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (redirect_valid) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_C;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - ONE_C;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Buffer storage; cleared on reset so the decode outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]  <= 32'd0;
                r_ins_mem[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_pc_mem[r_tail]  <= r_resp_pc;
            r_ins_mem[r_tail] <= imem_resp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redir_cnt;

    // Decode-starved cycles and redirect events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_redir_cnt <= 32'd0;
        end else begin
            if (id_ready && !id_valid) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_redir_cnt <= r_redir_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_stall_cnt = r_stall_cnt;
    assign perf_redirect_cnt    = r_redir_cnt;
`endif

    fetch_unit_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .resp_valid (imem_resp_valid),
        .buf_full   (r_count == DEPTH_C)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked against
// a queue-based model of the fetch stream, in-flight requests and the decode buffer.

module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        redirect_valid, id_valid, id_ready;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, id_instruction, id_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc)
    );

    typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;

    req_t        mq[$];
    ent_t        ef[$];
    logic [31:0] accepted[$];
    logic [31:0] popped[$];
    logic [31:0] next_fetch;
    int          cyc, last_due, lat;
    int          checks, failures;
    logic        s_req_v, s_id_v;
    logic [31:0] s_req_a, s_id_pc, s_id_ins;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < accepted.size()) ? accepted[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic step();
        bit   resp, pop_e, req_e, fire;
        req_t r;
        ent_t e;
        resp = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? word_of(mq[0].addr) : $urandom;
        #1;
        s_req_v = imem_req_valid; s_req_a = imem_req_addr;
        s_id_v = id_valid; s_id_pc = id_pc; s_id_ins = id_instruction;
        pop_e = (ef.size() > 0) && id_ready;
        req_e = !redirect_valid && ((mq.size() + ef.size() - (pop_e ? 1 : 0)) < DEPTH);
        chk("req_valid", {31'd0, s_req_v}, {31'd0, req_e});
        if (s_req_v) chk("req_addr", s_req_a, next_fetch);
        chk("id_valid", {31'd0, s_id_v}, {31'd0, (ef.size() > 0)});
        if (ef.size() > 0) begin
            chk("id_pc", s_id_pc, ef[0].pc);
            chk("id_instruction", s_id_ins, ef[0].ins);
        end
        fire = s_req_v && imem_req_ready;
        if (pop_e) begin
            popped.push_back(ef[0].pc);
            void'(ef.pop_front());
        end
        if (resp) begin
            r = mq.pop_front();
            if (!r.stale && !redirect_valid) begin
                e.pc = r.addr; e.ins = word_of(r.addr);
                ef.push_back(e);
            end
        end
        if (fire) begin
            r.addr = next_fetch;
            r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            r.stale = 1'b0;
            last_due = r.due;
            mq.push_back(r);
            accepted.push_back(s_req_a);
            next_fetch = next_fetch + 32'd4;
        end
        if (redirect_valid) begin
            ef.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            next_fetch = {redirect_pc[31:2], 2'b00};
        end
        chk("inflight_bound", {31'd0, ((mq.size() + ef.size()) <= DEPTH)}, 32'd1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instruction", id_instruction, 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        mq.delete(); ef.delete();
        next_fetch = RESET_PC;
        last_due = cyc;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          found;
        int          n_before;
        logic [31:0] head_pc;
        checks = 0; failures = 0; cyc = 0; last_due = 0; lat = 1;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b1;
        next_fetch = RESET_PC;
        @(negedge clk);
        do_reset();

        // Latency-1 streaming from reset.
        step(); chk("first_req_valid", {31'd0, s_req_v}, 32'd1); chk("first_req_addr", s_req_a, 32'h200);
        step(); chk("req2_addr", s_req_a, 32'h204);
        step(); chk("req3_addr", s_req_a, 32'h208); chk("first_id_pc", s_id_pc, 32'h200);
        step(); chk("id_pc_2", s_id_pc, 32'h204);
        step(); chk("id_pc_3", s_id_pc, 32'h208);
        n_before = popped.size();
        repeat (20) step();
        chk("throughput", popped.size() - n_before, 32'd20);

        // Decode stalled for 10 cycles, then released.
        do_reset();
        id_ready = 1'b0;
        repeat (10) step();
        id_ready = 1'b1; popped.delete();
        repeat (8) step();
        chk("release_pc0", pop_at(0), 32'h200);
        chk("release_pc1", pop_at(1), 32'h204);
        chk("release_pc2", pop_at(2), 32'h208);

        // Latency-3 redirect with two requests in flight.
        do_reset();
        lat = 3; accepted.delete(); popped.delete();
        step(); step();
        accepted.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
        step();
        chk("redirect_no_req", {31'd0, s_req_v}, 32'd0);
        redirect_valid = 1'b0;
        repeat (10) step();
        chk("redirect_first_req", acc_at(0), 32'h1000);
        chk("redirect_first_id_pc", pop_at(0), 32'h1000);

        // Redirect coinciding with a response and a decode handshake.
        do_reset();
        lat = 2; popped.delete(); found = 1'b0; n_before = 0; head_pc = 32'd0;
        repeat (3) step();
        for (int k = 0; k < 16 && !found; k++) begin
            if ((mq.size() > 0) && (mq[0].due <= cyc) && (ef.size() > 0)) begin
                head_pc = ef[0].pc; n_before = popped.size();
                redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
                step();
                redirect_valid = 1'b0; found = 1'b1;
            end else begin
                step();
            end
        end
        chk("coincident_found", {31'd0, found}, 32'd1);
        chk("handshake_once", popped.size(), n_before + 1);
        chk("handshake_pc", pop_at(n_before), head_pc);
        step();
        chk("flush_empty", {31'd0, s_id_v}, 32'd0);

        // Back-to-back redirects: the last one wins.
        lat = 1; accepted.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5000; step();
        redirect_pc = 32'h0000_6001; step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("last_redirect_wins", acc_at(0), 32'h6000);

        // Address wrap at the top of memory.
        accepted.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; step();
        redirect_valid = 1'b0;
        repeat (4) step();
        chk("wrap_req0", acc_at(0), 32'hFFFF_FFFC);
        chk("wrap_req1", acc_at(1), 32'h0000_0000);

        // Reset mid-stream with two outstanding requests.
        do_reset();
        lat = 3;
        step(); step();
        chk("two_outstanding", mq.size(), 32'd2);
        do_reset();
        step();
        chk("restart_req_valid", {31'd0, s_req_v}, 32'd1);
        chk("restart_req_addr", s_req_a, RESET_PC);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            if (k % 60 == 0) lat = $urandom_range(1, 4);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
